// File: rtl/conv_sa_wx_fifo_writer_pkg.sv
// Shared types and geometry for the wx FIFO writer.
// Geometry and tags come from the global defines when present.
`ifndef M
`define M 2
`endif
`ifndef P
`define P 2
`endif
`ifndef SA_TAG_DW
`define SA_TAG_DW 2
`endif
`ifndef SA_TAG_MID
`define SA_TAG_MID 1
`endif
`ifndef SA_TAG_END
`define SA_TAG_END 2
`endif

package conv_sa_wx_fifo_writer_pkg;

  localparam int M = `M;
  localparam int P = `P;
  localparam int SA_TAG_DW = `SA_TAG_DW;
  localparam logic [SA_TAG_DW-1:0] TAG_MID = `SA_TAG_MID;
  localparam logic [SA_TAG_DW-1:0] TAG_END = `SA_TAG_END;

  localparam int W_DW  = M * 32;
  localparam int X_DW  = P * 16;
  localparam int PL_DW = W_DW + X_DW;
  localparam int WX_DW = SA_TAG_DW + PL_DW;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    PAD,
    DONE
  } state_e;

  // 17 bits so lengths near 0xFFFF round up to 0x10000
  function automatic logic [16:0] calc_pad_len(
    input logic [15:0] len
  );
    logic [16:0] r;
    r = ({1'b0, len} + 17'd3) & ~17'd3;
    if (len == 16'd0) r = 17'd4;
    return r;
  endfunction

endpackage

// File: rtl/conv_sa_wx_fifo_writer_if.sv
// Command, weight, activation and wx FIFO signals of the writer.
interface conv_sa_wx_fifo_writer_if;
  import conv_sa_wx_fifo_writer_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [15:0]      cmd_ent_len;
  logic [15:0]      cmd_n_vec;
  logic             w_valid;
  logic             w_ready;
  logic [W_DW-1:0]  w_data;
  logic             x_valid;
  logic             x_ready;
  logic [X_DW-1:0]  x_data;
  logic             wx_fifo_wr_en;
  logic [WX_DW-1:0] wx_fifo_din;
  logic             wx_fifo_prog_full;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_ent_len, cmd_n_vec,
    output w_valid, w_data, x_valid, x_data,
    output wx_fifo_prog_full,
    input  cmd_ready, w_ready, x_ready,
    input  wx_fifo_wr_en, wx_fifo_din,
    input  busy, done
  );

  modport slave (
    input  cmd_valid, cmd_ent_len, cmd_n_vec,
    input  w_valid, w_data, x_valid, x_data,
    input  wx_fifo_prog_full,
    output cmd_ready, w_ready, x_ready,
    output wx_fifo_wr_en, wx_fifo_din,
    output busy, done
  );

endinterface

// File: rtl/conv_sa_wx_tagger.sv
// Picks data vs zero payload and the systolic-array tag
// for the word at the current entry position.
module conv_sa_wx_tagger
  import conv_sa_wx_fifo_writer_pkg::*;
(
  input  logic [16:0]          ent_cnt_i,
  input  logic [16:0]          pad_len_i,
  input  logic                 pad_i,
  output logic                 sel_data_o,
  output logic [SA_TAG_DW-1:0] tag_o
);

  logic is_end;

  assign is_end     = (ent_cnt_i + 17'd1) == pad_len_i;
  assign sel_data_o = !pad_i;
  assign tag_o      = is_end ? TAG_END : TAG_MID;

endmodule

// File: rtl/conv_sa_wx_fifo_writer.sv
// Joins weight and activation entries into tagged wx words,
// zero-padding each vector to a multiple of 4 entries.
module conv_sa_wx_fifo_writer
  import conv_sa_wx_fifo_writer_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  conv_sa_wx_fifo_writer_if.slave  bus
);

  state_e           state_q;
  logic [15:0]      ent_len_q;
  logic [15:0]      n_vec_q;
  logic [15:0]      vec_cnt_q;
  logic [16:0]      pad_len_q;
  logic [16:0]      ent_cnt_q;
  logic             wr_en_q;
  logic [WX_DW-1:0] din_q;

  logic                 pf;
  logic                 fire;
  logic                 in_pad;
  logic                 sel_data;
  logic [SA_TAG_DW-1:0] tag;
  logic [PL_DW-1:0]     payload;
  logic [WX_DW-1:0]     word;
  logic [16:0]          cnt_inc;
  logic [15:0]          vec_inc;
  logic                 data_last;
  logic                 pad_last;
  state_e               vec_nxt;

  assign pf     = bus.wx_fifo_prog_full;
  assign in_pad = state_q == PAD;

  // rst gating keeps every handshake low while reset is held
  assign bus.cmd_ready = state_q == IDLE && !rst;
  assign bus.w_ready   = state_q == SEND && bus.x_valid
                         && !pf && !rst;
  assign bus.x_ready   = state_q == SEND && bus.w_valid
                         && !pf && !rst;
  assign fire = bus.w_ready && bus.w_valid;

  conv_sa_wx_tagger u_tagger (
    .ent_cnt_i  (ent_cnt_q),
    .pad_len_i  (pad_len_q),
    .pad_i      (in_pad),
    .sel_data_o (sel_data),
    .tag_o      (tag)
  );

  assign payload = sel_data ? {bus.w_data, bus.x_data}
                            : '0;
  assign word    = {tag, payload};

  assign cnt_inc   = ent_cnt_q + 17'd1;
  assign vec_inc   = vec_cnt_q + 16'd1;
  assign data_last = cnt_inc == {1'b0, ent_len_q};
  assign pad_last  = cnt_inc == pad_len_q;
  assign vec_nxt   = (vec_inc == n_vec_q) ? DONE
                   : (ent_len_q == 16'd0) ? PAD
                   : SEND;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ent_len_q <= '0;
      n_vec_q   <= '0;
      vec_cnt_q <= '0;
      pad_len_q <= '0;
      ent_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            ent_len_q <= bus.cmd_ent_len;
            n_vec_q   <= bus.cmd_n_vec;
            pad_len_q <= calc_pad_len(bus.cmd_ent_len);
            ent_cnt_q <= '0;
            vec_cnt_q <= '0;
            if (bus.cmd_n_vec == 16'd0)
              state_q <= DONE;
            else if (bus.cmd_ent_len == 16'd0)
              state_q <= PAD;
            else
              state_q <= SEND;
          end
        end
        SEND: begin
          if (fire) begin
            wr_en_q <= 1'b1;
            din_q   <= word;
            if (data_last && pad_last) begin
              ent_cnt_q <= '0;
              vec_cnt_q <= vec_inc;
              state_q   <= vec_nxt;
            end else begin
              ent_cnt_q <= cnt_inc;
              if (data_last) state_q <= PAD;
            end
          end
        end
        PAD: begin
          if (!pf) begin
            wr_en_q <= 1'b1;
            din_q   <= word;
            if (pad_last) begin
              ent_cnt_q <= '0;
              vec_cnt_q <= vec_inc;
              state_q   <= vec_nxt;
            end else begin
              ent_cnt_q <= cnt_inc;
            end
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wx_fifo_wr_en = wr_en_q;
  assign bus.wx_fifo_din   = din_q;
  assign bus.busy          = state_q != IDLE;
  assign bus.done          = state_q == DONE;

endmodule

// File: tb/tb_conv_sa_wx_fifo_writer.sv
// Directed bench for the wx FIFO writer: command table
// plus stall, reset and back-pressure sequences.
module tb_conv_sa_wx_fifo_writer;
  import conv_sa_wx_fifo_writer_pkg::*;

  typedef logic [WX_DW-1:0] word_t;
  typedef struct {
    int len;
    int nv;
    bit pfr;
    int ewords;
    int ehs;
    int edone;
  } vec_t;

  vec_t tbl [7];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_sa_wx_fifo_writer_if bus();

  conv_sa_wx_fifo_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nmis = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int acc_cnt = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int w_hs = 0;
  int x_hs = 0;
  int wr_pf = 0;
  int rdy_pf = 0;
  int wrdy_cnt = 0;
  int k = 0;
  bit adv = 0;
  bit pf_rand = 0;
  bit pf_prev = 0;
  word_t wq[$];
  word_t eq[$];

  function automatic logic [W_DW-1:0] wpat(input int i);
    return {M{32'(i) ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [X_DW-1:0] xpat(input int i);
    return {P{16'(i) ^ 16'h5A00}};
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (bus.wx_fifo_wr_en === 1'b1) begin
      wq.push_back(bus.wx_fifo_din);
      if (pf_prev) wr_pf++;
    end
    pf_prev = bus.wx_fifo_prog_full;
    if (bus.w_ready === 1'b1) begin
      wrdy_cnt++;
      if (bus.wx_fifo_prog_full) rdy_pf++;
    end
    if (bus.w_valid && bus.w_ready === 1'b1) begin
      w_hs++;
      adv = 1;
    end
    if (bus.x_valid && bus.x_ready === 1'b1) x_hs++;
    if (bus.cmd_valid && bus.cmd_ready === 1'b1) begin
      acc_cyc = cyc;
      acc_cnt++;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (adv) begin
      k++;
      adv = 0;
    end
    bus.w_data = wpat(k);
    bus.x_data = xpat(k);
    if (pf_rand)
      bus.wx_fifo_prog_full = ($urandom_range(0, 2) == 0);
  end

  task automatic chk(input string nm,
                     input logic [127:0] a,
                     input logic [127:0] e);
    nvec++;
    if (a !== e) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  task automatic build(input int len, input int nv,
                       input int k0);
    int pl;
    int idx;
    logic [PL_DW-1:0] pl_w;
    logic [SA_TAG_DW-1:0] tg;
    eq.delete();
    pl = (len == 0) ? 4 : ((len + 3) / 4) * 4;
    idx = k0;
    for (int v = 0; v < nv; v++)
      for (int e = 0; e < pl; e++) begin
        pl_w = '0;
        if (e < len) begin
          pl_w = {wpat(idx), xpat(idx)};
          idx++;
        end
        tg = (e == pl - 1) ? TAG_END : TAG_MID;
        eq.push_back({tg, pl_w});
      end
  endtask

  task automatic issue(input int len, input int nv);
    int a0;
    a0 = acc_cnt;
    @(posedge clk); #2;
    bus.cmd_ent_len = 16'(len);
    bus.cmd_n_vec   = 16'(nv);
    bus.cmd_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      if (acc_cnt != a0) break;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accept", 128'(acc_cnt - a0), 128'd1);
  endtask

  task automatic wait_done(input int d0, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
    chk(nm, 128'(ok), 128'd1);
  endtask

  task automatic cmp_words(input string nm);
    chk({nm, "_nwords"}, 128'(wq.size()),
        128'(eq.size()));
    for (int i = 0; i < wq.size() && i < eq.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), 128'(wq[i]),
          128'(eq[i]));
  endtask

  task automatic run_cmd(input vec_t t, input int id);
    int w0, x0, d0, k0;
    string nm;
    nm = $sformatf("cmd%0d", id);
    wq.delete();
    w0 = w_hs; x0 = x_hs; d0 = done_cnt; k0 = k;
    build(t.len, t.nv, k0);
    pf_rand = t.pfr;
    issue(t.len, t.nv);
    wait_done(d0, {nm, "_done"});
    pf_rand = 0;
    bus.wx_fifo_prog_full = 1'b0;
    chk({nm, "_ewords"}, 128'(wq.size()), 128'(t.ewords));
    cmp_words(nm);
    chk({nm, "_w_hs"}, 128'(w_hs - w0), 128'(t.ehs));
    chk({nm, "_x_hs"}, 128'(x_hs - x0), 128'(t.ehs));
    if (t.edone >= 0)
      chk({nm, "_done_cyc"}, 128'(done_cyc - acc_cyc),
          128'(t.edone));
    chk({nm, "_done_pulse"}, 128'(bus.done), 128'd0);
    chk({nm, "_idle"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, r0, k0, d0;
    tbl[0] = '{8, 2, 1'b0, 16, 16, 17};
    tbl[1] = '{5, 1, 1'b0, 8, 5, 9};
    tbl[2] = '{0, 3, 1'b0, 12, 0, 13};
    tbl[3] = '{6, 4, 1'b1, 32, 24, -1};
    tbl[4] = '{3, 1, 1'b0, 4, 3, 5};
    tbl[5] = '{0, 0, 1'b0, 0, 0, 1};
    tbl[6] = '{4, 2, 1'b0, 8, 8, 9};

    bus.cmd_valid = 1'b0;
    bus.cmd_ent_len = '0;
    bus.cmd_n_vec = '0;
    bus.w_valid = 1'b1;
    bus.x_valid = 1'b1;
    bus.w_data = wpat(0);
    bus.x_data = xpat(0);
    bus.wx_fifo_prog_full = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
    chk("rst_w_ready", 128'(bus.w_ready), 128'd0);
    chk("rst_x_ready", 128'(bus.x_ready), 128'd0);
    chk("rst_wr_en", 128'(bus.wx_fifo_wr_en), 128'd0);
    chk("rst_din", 128'(bus.wx_fifo_din), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);

    for (int i = 0; i < 7; i++) run_cmd(tbl[i], i);

    // activation stream stalled while weights are offered
    wq.delete();
    bus.x_valid = 1'b0;
    k0 = k; w0 = w_hs; r0 = wrdy_cnt; d0 = done_cnt;
    build(2, 1, k0);
    issue(2, 1);
    repeat (10) @(posedge clk);
    #2;
    chk("stall_w_hs", 128'(w_hs - w0), 128'd0);
    chk("stall_w_ready", 128'(wrdy_cnt - r0), 128'd0);
    chk("stall_writes", 128'(wq.size()), 128'd0);
    chk("stall_k", 128'(k), 128'(k0));
    chk("stall_busy", 128'(bus.busy), 128'd1);
    bus.x_valid = 1'b1;
    wait_done(d0, "stall_done");
    cmp_words("stall");

    // reset in the middle of a vector
    wq.delete();
    issue(8, 1);
    for (int i = 0; i < 50; i++) begin
      if (wq.size() >= 3) break;
      @(posedge clk); #2;
    end
    chk("mid_three_words", 128'(wq.size() >= 3), 128'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_wr_en", 128'(bus.wx_fifo_wr_en), 128'd0);
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    chk("mid_rst_cmd_ready", 128'(bus.cmd_ready), 128'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    chk("mid_rel_wr_en", 128'(bus.wx_fifo_wr_en), 128'd0);
    run_cmd('{3, 2, 1'b0, 8, 6, 9}, 7);

    chk("wr_under_pf", 128'(wr_pf), 128'd0);
    chk("ready_under_pf", 128'(rdy_pf), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
